// File: rtl/db_mv_pkg.sv
// Shared constants for the deblocking MV RAM read controller.
//   DB_MV_ADR_W  : MV RAM address width (512 entries)
//   DB_MV_DAT_W  : MV word width
//   DB_MV_FIFO_D : default output skid FIFO depth
//   StIdle/StRun/StDrain : read controller FSM encoding
package db_mv_pkg;

  localparam int unsigned DB_MV_ADR_W  = 9;
  localparam int unsigned DB_MV_DAT_W  = 20;
  localparam int unsigned DB_MV_FIFO_D = 2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

endpackage

// File: rtl/db_mv_rd_ctrl_if.sv
// MV output stream (valid/ready) from the read controller to the boundary-strength logic.
//   mv_vld : word valid        (master -> slave)
//   mv_dat : MV word           (master -> slave)
//   mv_rdy : downstream ready  (slave -> master); transfer when mv_vld && mv_rdy
interface db_mv_rd_ctrl_if import db_mv_pkg::*; #(
  parameter int unsigned DAT_W = DB_MV_DAT_W
) ();

  logic             mv_vld;
  logic [DAT_W-1:0] mv_dat;
  logic             mv_rdy;

  modport master (output mv_vld, output mv_dat, input mv_rdy);
  modport slave  (input mv_vld, input mv_dat, output mv_rdy);

endinterface

// File: rtl/db_mv_skid_fifo.sv
// Small synchronous FIFO absorbing the one-cycle RAM read latency on the MV output path.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write push_dat_i (caller guarantees no overflow)
//   pop_i      : drop the head word; ignored when empty
//   vld_o      : FIFO non-empty
//   dat_o      : head word, straight from registered storage
//   cnt_o      : current fill level
module db_mv_skid_fifo import db_mv_pkg::*; #(
  parameter int unsigned  Depth = DB_MV_FIFO_D,
  parameter int unsigned  Width = DB_MV_DAT_W,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             vld_o,
  output logic [Width-1:0] dat_o,
  output logic [CntW-1:0]  cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i && (cnt_q != '0);
    if (push_i) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_i && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push_i && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign vld_o = (cnt_q != '0);
  assign dat_o = mem_q[rd_ptr_q];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/db_mv_rd_ctrl.sv
// Read-side controller for the single-port deblocking MV RAM (512x20). A start pulse streams
// cnt_i consecutive words from base_i (address wraps) out over valid/ready; the MV producer's
// write port is muxed onto the same RAM port and always wins.
//   clk, rst         : clock, synchronous active-high reset
//   start_i/base_i/cnt_i : burst request (cnt_i==0 means 2**ADR_W words), ignored while busy
//   busy_o, done_o   : burst active; one-cycle pulse after the last word is accepted
//   wr_req_i/wr_adr_i/wr_dat_i : producer write, no back-pressure
//   ram_*            : RAM port, active-low strobes, read data one cycle after the strobe
//   mv_if            : MV output stream (master side)
module db_mv_rd_ctrl import db_mv_pkg::*; #(
  parameter int unsigned ADR_W  = DB_MV_ADR_W,
  parameter int unsigned DAT_W  = DB_MV_DAT_W,
  parameter int unsigned FIFO_D = DB_MV_FIFO_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ADR_W-1:0] base_i,
  input  logic [ADR_W:0]   cnt_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             wr_req_i,
  input  logic [ADR_W-1:0] wr_adr_i,
  input  logic [DAT_W-1:0] wr_dat_i,
  output logic [ADR_W-1:0] ram_adr_o,
  output logic             ram_wr_ena_o,
  output logic             ram_rd_ena_o,
  output logic [DAT_W-1:0] ram_wr_dat_o,
  input  logic [DAT_W-1:0] ram_rd_dat_i,
  db_mv_rd_ctrl_if.master  mv_if
);

  localparam int unsigned RemW     = ADR_W + 1;
  localparam int unsigned FifoCntW = $clog2(FIFO_D + 1);

  logic [1:0]          state_q, state_d;
  logic [ADR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [RemW-1:0]     rem_q, rem_d;
  logic                inflight_q, inflight_d;

  logic                fifo_vld;
  logic [DAT_W-1:0]    fifo_dat;
  logic [FifoCntW-1:0] fifo_cnt;
  logic                pop;
  logic                wr_sel;
  logic                rd_issue;
  logic [31:0]         occ;
  logic [31:0]         lim;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    pop        = fifo_vld && mv_if.mv_rdy;
    wr_sel     = wr_req_i && !rst;
    // A word leaving the FIFO this cycle frees its slot in time for the read issued now,
    // which keeps a depth-2 FIFO at one word per cycle.
    occ        = 32'(fifo_cnt) + 32'(inflight_q);
    lim        = FIFO_D + 32'(pop);
    rd_issue   = !rst && (state_q == StRun) && (rem_q != '0) && !wr_req_i && (occ < lim);
    inflight_d = rd_issue;
    done_o     = !rst && (state_q == StDrain) && (rem_q == '0) && !inflight_q &&
                 (fifo_cnt == '0);

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          rd_ptr_d = base_i;
          rem_d    = (cnt_i == '0) ? {1'b1, {ADR_W{1'b0}}} : cnt_i;
        end
      end
      StRun: begin
        if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + ADR_W'(1);
          rem_d    = rem_q - RemW'(1);
          if (rem_q == RemW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (done_o) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ram_wr_ena_o = !wr_sel;
    ram_rd_ena_o = !rd_issue;
    ram_wr_dat_o = wr_sel ? wr_dat_i : '0;
    if (wr_sel) begin
      ram_adr_o = wr_adr_i;
    end else if (rd_issue) begin
      ram_adr_o = rd_ptr_q;
    end else begin
      ram_adr_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  db_mv_skid_fifo #(
    .Depth (FIFO_D),
    .Width (DAT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_dat_i (ram_rd_dat_i),
    .pop_i      (pop),
    .vld_o      (fifo_vld),
    .dat_o      (fifo_dat),
    .cnt_o      (fifo_cnt)
  );

  assign busy_o        = (state_q != StIdle);
  assign mv_if.mv_vld  = fifo_vld;
  assign mv_if.mv_dat  = fifo_dat;

endmodule
